wb_trace_buffer: RTL and testbench

Downstream consumer of the CPU's execute/write-back port. It captures every register write event (address, data) into a small FIFO and drains it to a bench or debug host over a valid/ready handshake. It also keeps a shadow copy of all 16 registers for direct inspection, with sticky overflow flagging and a saturating drop counter. It sits beside the register file on the write bus and never back-pressures the CPU.

---
 rtl/wb_trace_buffer_pkg.sv | 15 +
 rtl/wb_trace_buffer_if.sv | 37 +++
 rtl/wb_trace_buffer_fifo.sv | 72 +++++++
 rtl/wb_trace_buffer.sv | 75 +++++++
 tb/tb_wb_trace_buffer.sv | 340 ++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/wb_trace_buffer_pkg.sv
// Shared widths and the trace-entry record for the write-back trace buffer.
// The CPU write bus is sized from the same constants.
package wb_trace_buffer_pkg;

    localparam int TRACE_DEPTH = 8;
    localparam int REG_ADDR_W  = 4;
    localparam int REG_DATA_W  = 8;
    localparam int DROP_W      = 8;

    typedef struct packed {
        logic [REG_ADDR_W-1:0] addr;
        logic [REG_DATA_W-1:0] data;
    } trace_entry_t;

endpackage

// File: rtl/wb_trace_buffer_if.sv
// Write-bus, drain handshake, status and shadow-read signals of the trace buffer.
// The master side is the CPU/host environment and the slave side is the buffer.
interface wb_trace_buffer_if
    import wb_trace_buffer_pkg::*;
#(
    parameter int DEPTH  = TRACE_DEPTH,
    parameter int ADDR_W = REG_ADDR_W,
    parameter int DATA_W = REG_DATA_W
);
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic              i_stop;
    logic              i_write_en;
    logic [ADDR_W-1:0] i_write_add;
    logic [DATA_W-1:0] i_write_data;
    logic              i_clear;
    logic              o_valid;
    logic              i_ready;
    logic [ADDR_W-1:0] o_trace_add;
    logic [DATA_W-1:0] o_trace_data;
    logic [CNT_W-1:0]  o_count;
    logic              o_overflow;
    logic [DROP_W-1:0] o_drop_cnt;
    logic [ADDR_W-1:0] i_shadow_add;
    logic [DATA_W-1:0] o_shadow_data;

    modport master (
        output i_stop, i_write_en, i_write_add, i_write_data, i_clear, i_ready, i_shadow_add,
        input  o_valid, o_trace_add, o_trace_data, o_count, o_overflow, o_drop_cnt, o_shadow_data
    );

    modport slave (
        input  i_stop, i_write_en, i_write_add, i_write_data, i_clear, i_ready, i_shadow_add,
        output o_valid, o_trace_add, o_trace_data, o_count, o_overflow, o_drop_cnt, o_shadow_data
    );

endinterface

// File: rtl/wb_trace_buffer_fifo.sv
// First-word-fall-through FIFO whose head is held in a register, so the output
// keeps its last value once the queue runs empty.
module sync_fifo_fwft #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 12
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       clear,
    input  logic                       push,
    input  logic                       pop,
    input  logic [WIDTH-1:0]           wdata,
    output logic [WIDTH-1:0]           rdata,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       full,
    output logic                       empty
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] rd_ptr_nxt;
    logic [CNT_W-1:0] count_nxt;
    logic             do_push;
    logic             do_pop;

    assign full  = (count == CNT_W'(DEPTH));
    assign empty = (count == '0);

    always_comb begin
        do_pop     = pop & ~empty & ~clear;
        do_push    = push & ~clear & (~full | do_pop);
        rd_ptr_nxt = do_pop ? rd_ptr + PTR_W'(1) : rd_ptr;
        count_nxt  = count + CNT_W'(do_push) - CNT_W'(do_pop);
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wdata;
        end
    end

    // The head register loads the incoming word whenever it becomes the only entry.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            rdata  <= '0;
        end else if (clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            rd_ptr <= rd_ptr_nxt;
            count  <= count_nxt;
            if (count_nxt != '0) begin
                if (count == '0 || (count == CNT_W'(1) && do_pop)) begin
                    rdata <= wdata;
                end else begin
                    rdata <= mem[rd_ptr_nxt];
                end
            end
        end
    end

endmodule

// File: rtl/wb_trace_buffer.sv
// Captures register write events into a FIFO for a debug host, keeps a shadow
// copy of the register file, and counts events dropped while the FIFO is full.
module wb_trace_buffer
    import wb_trace_buffer_pkg::*;
#(
    parameter int DEPTH  = TRACE_DEPTH,
    parameter int ADDR_W = REG_ADDR_W,
    parameter int DATA_W = REG_DATA_W
) (
    input  logic              i_clk,
    input  logic              i_reset,
    wb_trace_buffer_if.slave  bus
);
    localparam int NREGS = 2 ** ADDR_W;

    logic                      push;
    logic                      pop;
    logic                      drop;
    logic                      fifo_full;
    logic                      fifo_empty;
    logic [ADDR_W+DATA_W-1:0]  head;
    logic [DATA_W-1:0]         shadow [NREGS];

    assign push = bus.i_write_en & ~bus.i_stop & ~bus.i_clear;
    assign pop  = bus.o_valid & bus.i_ready;
    // A pop in the same cycle frees the slot, so a full FIFO only drops without one.
    assign drop = push & fifo_full & ~pop;

    sync_fifo_fwft #(
        .DEPTH (DEPTH),
        .WIDTH (ADDR_W + DATA_W)
    ) u_fifo (
        .clk   (i_clk),
        .rst_n (i_reset),
        .clear (bus.i_clear),
        .push  (push),
        .pop   (pop),
        .wdata ({bus.i_write_add, bus.i_write_data}),
        .rdata (head),
        .count (bus.o_count),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign bus.o_valid       = ~fifo_empty;
    assign bus.o_trace_add   = head[ADDR_W+DATA_W-1:DATA_W];
    assign bus.o_trace_data  = head[DATA_W-1:0];
    assign bus.o_shadow_data = shadow[bus.i_shadow_add];

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            bus.o_overflow <= 1'b0;
            bus.o_drop_cnt <= '0;
        end else if (bus.i_clear) begin
            bus.o_overflow <= 1'b0;
            bus.o_drop_cnt <= '0;
        end else if (drop) begin
            bus.o_overflow <= 1'b1;
            if (bus.o_drop_cnt != '1) begin
                bus.o_drop_cnt <= bus.o_drop_cnt + DROP_W'(1);
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            for (int r = 0; r < NREGS; r++) begin
                shadow[r] <= '0;
            end
        end else if (push) begin
            shadow[bus.i_write_add] <= bus.i_write_data;
        end
    end

endmodule

// File: tb/tb_wb_trace_buffer.sv
// Self-checking bench for wb_trace_buffer: directed scenarios plus a randomized
// run, all checked against a queue-based model of the trace buffer.
module tb_wb_trace_buffer;
    import wb_trace_buffer_pkg::*;

    localparam int NREGS = 16;

    logic clk;
    logic rst_n;
    int   vectors;
    int   miscompares;

    trace_entry_t m_q[$];
    trace_entry_t m_head;
    logic [7:0]   m_shadow [NREGS];
    logic         m_overflow;
    int           m_drop;

    wb_trace_buffer_if #(.DEPTH(TRACE_DEPTH), .ADDR_W(REG_ADDR_W), .DATA_W(REG_DATA_W)) bus ();

    wb_trace_buffer dut (
        .i_clk   (clk),
        .i_reset (rst_n),
        .bus     (bus)
    );

    initial begin
        clk = 1'b0;
        forever #50 clk = ~clk;
    end

    task automatic model_reset();
        m_q.delete();
        m_head     = '0;
        m_overflow = 1'b0;
        m_drop     = 0;
        for (int r = 0; r < NREGS; r++) m_shadow[r] = '0;
    endtask

    // Behaviour at one clock edge: the consumer takes the head, then the new
    // event goes in if there is room.
    task automatic model_step(input logic en, input logic [3:0] a, input logic [7:0] d,
                              input logic stop, input logic clr, input logic rdy);
        trace_entry_t e;
        if (clr) begin
            m_q.delete();
            m_overflow = 1'b0;
            m_drop     = 0;
        end else begin
            if (rdy && m_q.size() > 0) void'(m_q.pop_front());
            if (en && !stop) begin
                m_shadow[a] = d;
                e.addr = a;
                e.data = d;
                if (m_q.size() < TRACE_DEPTH) begin
                    m_q.push_back(e);
                end else begin
                    m_overflow = 1'b1;
                    if (m_drop < 255) m_drop++;
                end
            end
        end
        if (m_q.size() > 0) m_head = m_q[0];
    endtask

    task automatic cycle(input logic en, input logic [3:0] a, input logic [7:0] d,
                         input logic stop, input logic clr, input logic rdy);
        bus.i_write_en   = en;
        bus.i_write_add  = a;
        bus.i_write_data = d;
        bus.i_stop       = stop;
        bus.i_clear      = clr;
        bus.i_ready      = rdy;
        model_step(en, a, d, stop, clr, rdy);
        @(posedge clk);
        #1;
        bus.i_write_en = 1'b0;
        bus.i_stop     = 1'b0;
        bus.i_clear    = 1'b0;
        bus.i_ready    = 1'b0;
    endtask

    task automatic test_reset();
        vectors++;
        if (bus.o_valid !== 1'b0 || bus.o_count !== 4'd0) begin
            $display("FAIL reset_fifo: valid=%b count=%0d, required valid=0 count=0", bus.o_valid, bus.o_count);
            miscompares++;
        end
        vectors++;
        if (bus.o_overflow !== 1'b0 || bus.o_drop_cnt !== 8'd0) begin
            $display("FAIL reset_drop: ovf=%b drop=%0d, required 0/0", bus.o_overflow, bus.o_drop_cnt);
            miscompares++;
        end
        vectors++;
        if (bus.o_trace_add !== 4'd0 || bus.o_trace_data !== 8'd0) begin
            $display("FAIL reset_trace: (%0h,%0h), required (0,0)", bus.o_trace_add, bus.o_trace_data);
            miscompares++;
        end
        for (int r = 0; r < NREGS; r++) begin
            bus.i_shadow_add = 4'(r);
            #1;
            vectors++;
            if (bus.o_shadow_data !== 8'd0) begin
                $display("FAIL reset_shadow[%0d]: got %0h, required 0", r, bus.o_shadow_data);
                miscompares++;
            end
        end
    endtask

    task automatic test_single();
        cycle(1'b1, 4'd3, 8'h5A, 1'b0, 1'b0, 1'b0);
        bus.i_shadow_add = 4'd3;
        #1;
        vectors++;
        if (bus.o_valid !== 1'b1 || bus.o_count !== 4'd1) begin
            $display("FAIL single_valid: valid=%b count=%0d, required 1/1", bus.o_valid, bus.o_count);
            miscompares++;
        end
        vectors++;
        if (bus.o_trace_add !== 4'd3 || bus.o_trace_data !== 8'h5A) begin
            $display("FAIL single_trace: (%0h,%0h), required (3,5a)", bus.o_trace_add, bus.o_trace_data);
            miscompares++;
        end
        vectors++;
        if (bus.o_shadow_data !== 8'h5A) begin
            $display("FAIL single_shadow: got %0h, required 5a", bus.o_shadow_data);
            miscompares++;
        end
        cycle(1'b0, 4'd0, 8'd0, 1'b0, 1'b0, 1'b1);
        vectors++;
        if (bus.o_valid !== 1'b0 || bus.o_count !== 4'd0) begin
            $display("FAIL single_drain: valid=%b count=%0d, required 0/0", bus.o_valid, bus.o_count);
            miscompares++;
        end
        vectors++;
        if (bus.o_trace_add !== 4'd3 || bus.o_trace_data !== 8'h5A) begin
            $display("FAIL single_hold: (%0h,%0h), required (3,5a)", bus.o_trace_add, bus.o_trace_data);
            miscompares++;
        end
    endtask

    task automatic test_overflow();
        for (int i = 0; i < 10; i++) cycle(1'b1, 4'(i), 8'(8'h10 + i), 1'b0, 1'b0, 1'b0);
        bus.i_shadow_add = 4'd9;
        #1;
        vectors++;
        if (bus.o_count !== 4'd8 || bus.o_overflow !== 1'b1 || bus.o_drop_cnt !== 8'd2) begin
            $display("FAIL overflow_status: count=%0d ovf=%b drop=%0d, required 8/1/2",
                     bus.o_count, bus.o_overflow, bus.o_drop_cnt);
            miscompares++;
        end
        vectors++;
        if (bus.o_shadow_data !== 8'h19) begin
            $display("FAIL overflow_shadow9: got %0h, required 19", bus.o_shadow_data);
            miscompares++;
        end
        for (int k = 0; k < 8; k++) begin
            vectors++;
            if (bus.o_valid !== 1'b1 || bus.o_trace_add !== 4'(k) || bus.o_trace_data !== 8'(8'h10 + k)) begin
                $display("FAIL overflow_order[%0d]: v=%b (%0h,%0h), required (%0h,%0h)",
                         k, bus.o_valid, bus.o_trace_add, bus.o_trace_data, k, 8'h10 + k);
                miscompares++;
            end
            cycle(1'b0, 4'd0, 8'd0, 1'b0, 1'b0, 1'b1);
        end
        vectors++;
        if (bus.o_count !== 4'd0 || bus.o_drop_cnt !== 8'd2 || bus.o_overflow !== 1'b1) begin
            $display("FAIL overflow_after: count=%0d drop=%0d ovf=%b, required 0/2/1",
                     bus.o_count, bus.o_drop_cnt, bus.o_overflow);
            miscompares++;
        end
    endtask

    task automatic test_full_pushpop();
        cycle(1'b0, 4'd0, 8'd0, 1'b0, 1'b1, 1'b0);
        vectors++;
        if (bus.o_overflow !== 1'b0 || bus.o_drop_cnt !== 8'd0) begin
            $display("FAIL clear_flags: ovf=%b drop=%0d, required 0/0", bus.o_overflow, bus.o_drop_cnt);
            miscompares++;
        end
        for (int i = 0; i < 8; i++) cycle(1'b1, 4'($urandom), 8'($urandom), 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 4'hA, 8'hEE, 1'b0, 1'b0, 1'b1);
        vectors++;
        if (bus.o_count !== 4'd8 || bus.o_drop_cnt !== 8'd0 || bus.o_overflow !== 1'b0) begin
            $display("FAIL fullpp_status: count=%0d drop=%0d ovf=%b, required 8/0/0",
                     bus.o_count, bus.o_drop_cnt, bus.o_overflow);
            miscompares++;
        end
        for (int k = 0; k < 8; k++) begin
            vectors++;
            if (bus.o_trace_add !== m_q[0].addr || bus.o_trace_data !== m_q[0].data) begin
                $display("FAIL fullpp_order[%0d]: (%0h,%0h), required (%0h,%0h)",
                         k, bus.o_trace_add, bus.o_trace_data, m_q[0].addr, m_q[0].data);
                miscompares++;
            end
            if (k == 7) begin
                vectors++;
                if (bus.o_trace_add !== 4'hA || bus.o_trace_data !== 8'hEE) begin
                    $display("FAIL fullpp_last: (%0h,%0h), required (a,ee)", bus.o_trace_add, bus.o_trace_data);
                    miscompares++;
                end
            end
            cycle(1'b0, 4'd0, 8'd0, 1'b0, 1'b0, 1'b1);
        end
    endtask

    task automatic test_stop();
        logic [3:0] a;
        cycle(1'b1, 4'd1, 8'h11, 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 4'd2, 8'h22, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            a = 4'(4 + i);
            cycle(1'b1, a, 8'($urandom | 1), 1'b1, 1'b0, 1'b0);
            bus.i_shadow_add = a;
            #1;
            vectors++;
            if (bus.o_count !== 4'd2 || bus.o_shadow_data !== m_shadow[a]) begin
                $display("FAIL stop_hold[%0d]: count=%0d shadow=%0h, required 2/%0h",
                         i, bus.o_count, bus.o_shadow_data, m_shadow[a]);
                miscompares++;
            end
        end
        cycle(1'b0, 4'd0, 8'd0, 1'b1, 1'b0, 1'b1);
        vectors++;
        if (bus.o_count !== 4'd1 || bus.o_trace_add !== 4'd2 || bus.o_trace_data !== 8'h22) begin
            $display("FAIL stop_drain: count=%0d (%0h,%0h), required 1 (2,22)",
                     bus.o_count, bus.o_trace_add, bus.o_trace_data);
            miscompares++;
        end
        cycle(1'b0, 4'd0, 8'd0, 1'b1, 1'b0, 1'b1);
    endtask

    task automatic test_saturate_clear();
        for (int i = 0; i < 308; i++) cycle(1'b1, 4'($urandom), 8'($urandom), 1'b0, 1'b0, 1'b0);
        vectors++;
        if (bus.o_drop_cnt !== 8'd255 || bus.o_overflow !== 1'b1 || bus.o_count !== 4'd8) begin
            $display("FAIL saturate: drop=%0d ovf=%b count=%0d, required 255/1/8",
                     bus.o_drop_cnt, bus.o_overflow, bus.o_count);
            miscompares++;
        end
        cycle(1'b1, 4'd7, 8'h99, 1'b0, 1'b1, 1'b0);
        vectors++;
        if (bus.o_count !== 4'd0 || bus.o_overflow !== 1'b0 || bus.o_drop_cnt !== 8'd0 || bus.o_valid !== 1'b0) begin
            $display("FAIL clear_state: count=%0d ovf=%b drop=%0d valid=%b, required 0/0/0/0",
                     bus.o_count, bus.o_overflow, bus.o_drop_cnt, bus.o_valid);
            miscompares++;
        end
        for (int r = 0; r < NREGS; r++) begin
            bus.i_shadow_add = 4'(r);
            #1;
            vectors++;
            if (bus.o_shadow_data !== m_shadow[r]) begin
                $display("FAIL clear_shadow[%0d]: got %0h, required %0h", r, bus.o_shadow_data, m_shadow[r]);
                miscompares++;
            end
        end
    endtask

    task automatic test_async_reset();
        for (int i = 0; i < 4; i++) cycle(1'b1, 4'(8 + i), 8'($urandom | 1), 1'b0, 1'b0, 1'b0);
        #20;
        rst_n = 1'b0;
        model_reset();
        #1;
        vectors++;
        if (bus.o_valid !== 1'b0 || bus.o_count !== 4'd0 || bus.o_trace_add !== 4'd0 || bus.o_trace_data !== 8'd0) begin
            $display("FAIL areset_fifo: valid=%b count=%0d (%0h,%0h), required 0/0 (0,0)",
                     bus.o_valid, bus.o_count, bus.o_trace_add, bus.o_trace_data);
            miscompares++;
        end
        for (int r = 8; r < 12; r++) begin
            bus.i_shadow_add = 4'(r);
            #1;
            vectors++;
            if (bus.o_shadow_data !== 8'd0) begin
                $display("FAIL areset_shadow[%0d]: got %0h, required 0", r, bus.o_shadow_data);
                miscompares++;
            end
        end
        #5;
        rst_n = 1'b1;
        cycle(1'b1, 4'd5, 8'h77, 1'b0, 1'b0, 1'b0);
        vectors++;
        if (bus.o_valid !== 1'b1 || bus.o_count !== 4'd1 || bus.o_trace_add !== 4'd5 || bus.o_trace_data !== 8'h77) begin
            $display("FAIL areset_resume: valid=%b count=%0d (%0h,%0h), required 1/1 (5,77)",
                     bus.o_valid, bus.o_count, bus.o_trace_add, bus.o_trace_data);
            miscompares++;
        end
    endtask

    task automatic test_random();
        logic [3:0] sa;
        for (int n = 0; n < 600; n++) begin
            sa = 4'($urandom);
            bus.i_shadow_add = sa;
            cycle(1'($urandom_range(0, 3) != 0), 4'($urandom), 8'($urandom),
                  1'($urandom_range(0, 9) == 0), 1'($urandom_range(0, 39) == 0),
                  1'($urandom_range(0, 2) == 0));
            vectors++;
            if (bus.o_valid !== (m_q.size() != 0) || bus.o_count !== 4'(m_q.size())
                || bus.o_trace_add !== m_head.addr || bus.o_trace_data !== m_head.data
                || bus.o_overflow !== m_overflow || bus.o_drop_cnt !== 8'(m_drop)
                || bus.o_shadow_data !== m_shadow[sa]) begin
                $display("FAIL random[%0d]: v=%b c=%0d (%0h,%0h) ovf=%b drop=%0d sh=%0h, required v=%b c=%0d (%0h,%0h) ovf=%b drop=%0d sh=%0h",
                         n, bus.o_valid, bus.o_count, bus.o_trace_add, bus.o_trace_data, bus.o_overflow,
                         bus.o_drop_cnt, bus.o_shadow_data, m_q.size() != 0, m_q.size(), m_head.addr,
                         m_head.data, m_overflow, m_drop, m_shadow[sa]);
                miscompares++;
            end
        end
    endtask

    initial begin
        vectors          = 0;
        miscompares      = 0;
        rst_n            = 1'b0;
        bus.i_stop       = 1'b0;
        bus.i_write_en   = 1'b0;
        bus.i_write_add  = '0;
        bus.i_write_data = '0;
        bus.i_clear      = 1'b0;
        bus.i_ready      = 1'b0;
        bus.i_shadow_add = '0;
        model_reset();
        #12;
        test_reset();
        #10;
        rst_n = 1'b1;
        test_single();
        test_overflow();
        test_full_pushpop();
        test_stop();
        test_saturate_clear();
        test_async_reset();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
